dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port round-robin arbiter that shares the single-port synchronous data memory (DMEM) of the RV32I core between requester 0 (core load/store unit) and requester 1 (debug/DMA loader). It sits between the core datapath and DMEM inside `rv32I_top`. The core treats `r0_req & ~r0_gnt` as a stall that holds `curr_pc`.

## Interface
- `ADDR_W`, 32, byte address width
- `DATA_W`, 32, data width; byte-enable width is `DATA_W/8`
- `LOCK_MAX`, 16, maximum locked cycles before forced release (used only with `DMEM_ARB_LOCK_EN`)

Ports:
- `clk`  in  1  system clock; all logic on its rising edge
- `reset`  in  1  synchronous, active-low reset (0 = reset)
- `r0_req`, `r1_req`  in  1  request valid
- `r0_we`, `r1_we`  in  1  1 = write, 0 = read
- `r0_addr`, `r1_addr`  in  ADDR_W  byte address, passed through unchanged
- `r0_wdata`, `r1_wdata`  in  DATA_W  write data
- `r0_be`, `r1_be`  in  DATA_W/8  byte enables
- `r1_lock`  in  1  hold grant for requester 1 (macro only)
- `r0_gnt`, `r1_gnt`  out  1  request accepted this cycle (combinational)
- `r0_rvalid`, `r1_rvalid`  out  1  read data valid
- `r0_rdata`, `r1_rdata`  out  DATA_W  read data, 0 when the matching rvalid is 0
- `mem_en`, `mem_we`  out  1  DMEM command
- `mem_addr`  out  ADDR_W; `mem_wdata`  out  DATA_W; `mem_be`  out  DATA_W/8
- `mem_rdata`  in  DATA_W  DMEM read data, valid 1 cycle after a read command

## Operation
- A requester keeps `req`, `we`, `addr`, `wdata`, and `be` stable from assertion until the cycle its `gnt` is high. Dropping `req` before grant is legal; nothing is issued.
- At most one grant per cycle. `mem_*` are driven from the granted port; `mem_en = r0_gnt | r1_gnt`.
- Round robin uses a 1-bit `last` register that records the last granted port.
  - If both ports request, the port ≠ `last` wins.
  - If only one port requests, it wins, even if it equals `last`.
  - `last` updates on every grant.
- Read return uses registered `rd_pend` and `rd_sel`, set on a granted read. Next cycle, `rN_rvalid = rd_pend & (rd_sel==N)` and `rN_rdata = mem_rdata`, gated by that rvalid.
- Writes produce no response.
- FSM states are ARB and LOCKED. LOCKED exists only with `DMEM_ARB_LOCK_EN`.
- Reset (`reset`=0 at a rising edge):
  - `last`=1, so r0 wins the first conflict.
  - `rd_pend`=0, state=ARB, `lock_cnt`=0.
  - While `reset`=0, all `gnt` are forced to 0 and `mem_en`=0.
  - All `rvalid`=0 and all `rdata`=0 from the first reset edge on.
  - A read granted in the cycle before reset asserts is dropped; its rvalid never appears.

## Timing
- Grant latency: 0 cycles (grant is combinational in the request cycle). An uncontested requester is granted every cycle, back to back.
- Read latency: rvalid is high exactly 1 cycle after the grant cycle, for 1 cycle.
- A granted write commits to DMEM on the grant-cycle edge. A read of the same address in the next cycle returns the new data.
- Under continuous contention each port is granted every other cycle. Worst-case wait for the loser is 1 cycle (ARB state only).
- Back-to-back reads alternating between ports give back-to-back rvalids on alternating ports.

## Configuration
- `DMEM_ARB_LOCK_EN` defined:
  - **Entering LOCKED:** a granted r1 request with `r1_lock`=1 moves ARB→LOCKED and clears `lock_cnt`.
  - **Behaviour in LOCKED:** `r0_gnt`=0, r1 is granted whenever it requests, and `lock_cnt` increments every cycle.
  - **Normal exit:** LOCKED→ARB after a granted r1 request with `r1_lock`=0. That request completes normally.
  - **Forced exit:** when `lock_cnt` reaches `LOCK_MAX`-1, return to ARB and set `last`=1, so r0 wins the next conflict. `r1_lock` is ignored for 1 cycle after a forced exit.
- `DMEM_ARB_LOCK_EN` undefined: `r1_lock` is ignored, there is no LOCKED state and no counter, and behaviour is pure round robin.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with both `req`=1 → both `gnt`=0, `mem_en`=0, all rvalid/rdata 0. First cycle after release: `r0_gnt`=1.
- r0 alone: write 0xDEADBEEF to 0x10 with `be`=0xF, then read 0x10 → rvalid 1 cycle after the read grant, `r0_rdata`=0xDEADBEEF, `r1_rvalid`=0.
- Contention: both ports read continuously for 6 cycles → grants alternate r0,r1,r0,r1,r0,r1; each rvalid pulses on the matching port one cycle later.
- Byte enables: preload 0x11223344 at 0x20; r1 writes 0xAABBCCDD with `be`=0x3; read back → 0x1122CCDD.
- Mid-read reset: grant r0 read, then drive `reset`=0 on the next edge → `r0_rvalid` stays 0.
- Lock (macro on, `LOCK_MAX`=4): r1 requests with lock held and r0 requests continuously → r0 is starved for exactly 4 cycles, then the forced release grants r0 in the next cycle.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Requester / DMEM bundle for dmem_arbiter.
// master: requesters + DMEM side, slave: arbiter side.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              r0_req;
  logic              r0_we;
  logic [ADDR_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_wdata;
  logic [BE_W-1:0]   r0_be;
  logic              r0_gnt;
  logic              r0_rvalid;
  logic [DATA_W-1:0] r0_rdata;

  logic              r1_req;
  logic              r1_we;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_wdata;
  logic [BE_W-1:0]   r1_be;
  logic              r1_lock;
  logic              r1_gnt;
  logic              r1_rvalid;
  logic [DATA_W-1:0] r1_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output r0_req, r0_we, r0_addr, r0_wdata, r0_be,
    output r1_req, r1_we, r1_addr, r1_wdata, r1_be,
    output r1_lock, mem_rdata,
    input  r0_gnt, r0_rvalid, r0_rdata,
    input  r1_gnt, r1_rvalid, r1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport slave (
    input  r0_req, r0_we, r0_addr, r0_wdata, r0_be,
    input  r1_req, r1_we, r1_addr, r1_wdata, r1_be,
    input  r1_lock, mem_rdata,
    output r0_gnt, r0_rvalid, r0_rdata,
    output r1_gnt, r1_rvalid, r1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing single-port DMEM between r0 (LSU) and r1.
// Ports: clk, reset (sync, active-low), bus (dmem_arbiter_if.slave).
// Optional r1 bus lock with forced release: `define DMEM_ARB_LOCK_EN.
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave bus
);

  logic g0;
  logic g1;
  logic any_g;
  logic last;
  logic rd_pend;
  logic rd_sel;
  logic rv0;
  logic rv1;
  logic r0_ok;
  logic force_rel;

  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [DATA_W/8-1:0] sel_be;
  logic                sel_we;

`ifdef DMEM_ARB_LOCK_EN
  localparam int CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

  typedef enum logic {
    ARB,
    LOCKED
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] lock_cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic             lock_blk;
  logic             blk_nx;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ARB;
      lock_cnt <= '0;
      lock_blk <= 1'b0;
    end else begin
      state    <= state_nx;
      lock_cnt <= cnt_nx;
      lock_blk <= blk_nx;
    end
  end

  // lock_blk masks r1_lock for the one cycle after a forced release
  always_comb begin
    state_nx  = state;
    cnt_nx    = lock_cnt;
    blk_nx    = 1'b0;
    force_rel = 1'b0;
    case (state)
      ARB: begin
        if (g1 && bus.r1_lock && !lock_blk) begin
          state_nx = LOCKED;
          cnt_nx   = '0;
        end
      end
      LOCKED: begin
        cnt_nx = lock_cnt + 1'b1;
        if (lock_cnt == CNT_W'(LOCK_MAX - 1)) begin
          state_nx  = ARB;
          force_rel = 1'b1;
          blk_nx    = 1'b1;
        end else if (g1 && !bus.r1_lock) begin
          state_nx = ARB;
        end
      end
      default: state_nx = ARB;
    endcase
  end

  assign r0_ok = (state == ARB);
`else
  logic lock_unused;

  assign lock_unused = bus.r1_lock | (LOCK_MAX < 1);
  assign r0_ok       = 1'b1;
  assign force_rel   = 1'b0;
`endif

  // last = 1 favours r0 on a conflict
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (!reset) begin
      g0 = 1'b0;
      g1 = 1'b0;
    end else if (!r0_ok) begin
      g1 = bus.r1_req;
    end else if (bus.r0_req && bus.r1_req) begin
      g0 = last;
      g1 = !last;
    end else begin
      g0 = bus.r0_req;
      g1 = bus.r1_req;
    end
  end

  assign any_g = g0 | g1;

  assign sel_addr  = g1 ? bus.r1_addr  : bus.r0_addr;
  assign sel_wdata = g1 ? bus.r1_wdata : bus.r0_wdata;
  assign sel_be    = g1 ? bus.r1_be    : bus.r0_be;
  assign sel_we    = g1 ? bus.r1_we    : bus.r0_we;

  assign bus.r0_gnt    = g0;
  assign bus.r1_gnt    = g1;
  assign bus.mem_en    = any_g;
  assign bus.mem_we    = any_g & sel_we;
  assign bus.mem_addr  = sel_addr;
  assign bus.mem_wdata = sel_wdata;
  assign bus.mem_be    = sel_be;

  always_ff @(posedge clk) begin
    if (!reset) begin
      last    <= 1'b1;
      rd_pend <= 1'b0;
      rd_sel  <= 1'b0;
    end else begin
      if (force_rel) begin
        last <= 1'b1;
      end else if (any_g) begin
        last <= g1;
      end
      rd_pend <= any_g & ~sel_we;
      rd_sel  <= g1;
    end
  end

  // gating with reset drops a read whose grant edge coincides
  // with reset assertion
  assign rv0 = reset & rd_pend & ~rd_sel;
  assign rv1 = reset & rd_pend & rd_sel;

  assign bus.r0_rvalid = rv0;
  assign bus.r1_rvalid = rv1;
  assign bus.r0_rdata  = rv0 ? bus.mem_rdata : '0;
  assign bus.r1_rdata  = rv1 ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed steps + random traffic
// against a round-robin / memory reference model.
module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LMAX = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_arbiter #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .LOCK_MAX(LMAX)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // DMEM fixture: synchronous single-port RAM
  logic [31:0] ram [0:255];

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_be[b])
            ram[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end else begin
        bus.mem_rdata <= ram[bus.mem_addr[9:2]];
      end
    end
  end

  // reference model state
  logic [31:0] ref_mem [0:255];
  logic        last_m = 1'b1;
  logic        pv = 1'b0;
  logic        psel = 1'b0;
  logic [31:0] pdat = '0;
  logic        eg0 = 1'b0;
  logic        eg1 = 1'b0;
  logic        og0, og1, orv0, orv1;
  logic [31:0] ord0, ord1;
`ifdef DMEM_ARB_LOCK_EN
  logic        in_lock = 1'b0;
  logic        blk = 1'b0;
  int          lock_left = 0;
`endif

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ref_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] be);
    for (int b = 0; b < 4; b++)
      if (be[b]) ref_mem[a[9:2]][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic set0(input logic req, input logic we,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be);
    bus.r0_req = req; bus.r0_we = we; bus.r0_addr = a;
    bus.r0_wdata = d; bus.r0_be = be;
  endtask

  task automatic set1(input logic req, input logic we,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, input logic lk);
    bus.r1_req = req; bus.r1_we = we; bus.r1_addr = a;
    bus.r1_wdata = d; bus.r1_be = be; bus.r1_lock = lk;
  endtask

  // Called at posedge+1 with inputs applied; checks at negedge,
  // advances the model on the next posedge, returns at posedge+1.
  task automatic cycle();
    logic e0, e1, locked_now, x0, x1;
    logic [31:0] xa;
    e0 = 1'b0;
    e1 = 1'b0;
    locked_now = 1'b0;
`ifdef DMEM_ARB_LOCK_EN
    locked_now = in_lock;
`endif
    if (!reset) begin
      e0 = 1'b0;
    end else if (locked_now) begin
      e1 = bus.r1_req;
    end else if (bus.r0_req && bus.r1_req) begin
      e0 = last_m;
      e1 = !last_m;
    end else begin
      e0 = bus.r0_req;
      e1 = bus.r1_req;
    end
    x0 = reset && pv && !psel;
    x1 = reset && pv && psel;
    #4;
    og0 = bus.r0_gnt; og1 = bus.r1_gnt;
    orv0 = bus.r0_rvalid; orv1 = bus.r1_rvalid;
    ord0 = bus.r0_rdata; ord1 = bus.r1_rdata;
    chk("r0_gnt", og0, e0);
    chk("r1_gnt", og1, e1);
    chk("mem_en", bus.mem_en, e0 | e1);
    chk("r0_rvalid", orv0, x0);
    chk("r1_rvalid", orv1, x1);
    chk("r0_rdata", ord0, x0 ? pdat : 32'h0);
    chk("r1_rdata", ord1, x1 ? pdat : 32'h0);
    if (e0 || e1) begin
      xa = e1 ? bus.r1_addr : bus.r0_addr;
      chk("mem_addr", bus.mem_addr, xa);
      chk("mem_we", bus.mem_we, e1 ? bus.r1_we : bus.r0_we);
    end
    @(posedge clk);
    eg0 = e0;
    eg1 = e1;
    if (!reset) begin
      last_m = 1'b1;
      pv = 1'b0;
`ifdef DMEM_ARB_LOCK_EN
      in_lock = 1'b0;
      blk = 1'b0;
`endif
    end else begin
      if (e0 || e1) last_m = e1;
      pv = (e0 && !bus.r0_we) || (e1 && !bus.r1_we);
      psel = e1;
      if (e0) begin
        pdat = ref_mem[bus.r0_addr[9:2]];
        if (bus.r0_we) ref_write(bus.r0_addr, bus.r0_wdata, bus.r0_be);
      end
      if (e1) begin
        pdat = ref_mem[bus.r1_addr[9:2]];
        if (bus.r1_we) ref_write(bus.r1_addr, bus.r1_wdata, bus.r1_be);
      end
`ifdef DMEM_ARB_LOCK_EN
      if (in_lock) begin
        lock_left--;
        blk = 1'b0;
        if (lock_left == 0) begin
          in_lock = 1'b0;
          last_m = 1'b1;
          blk = 1'b1;
        end else if (e1 && !bus.r1_lock) begin
          in_lock = 1'b0;
        end
      end else begin
        if (e1 && bus.r1_lock && !blk) begin
          in_lock = 1'b1;
          lock_left = LMAX;
        end
        blk = 1'b0;
      end
`endif
    end
    #1;
  endtask

  task automatic rnd(output logic req, output logic we,
                     output logic [31:0] a, output logic [31:0] d,
                     output logic [3:0] be);
    req = ($urandom_range(0, 9) < 6);
    we = 1'($urandom_range(0, 1));
    a = 32'($urandom_range(0, 15)) << 2;
    d = $urandom;
    be = 4'($urandom_range(0, 15));
  endtask

  initial begin
    logic q, w, lk;
    logic [31:0] a, d;
    logic [3:0] be;
    int starve;

    for (int i = 0; i < 256; i++) begin
      ram[i] = '0;
      ref_mem[i] = '0;
    end
    bus.mem_rdata = '0;

    // reset with both requesting
    reset = 1'b0;
    set0(1, 0, 32'h0, 32'h0, 4'hF);
    set1(1, 0, 32'h4, 32'h0, 4'hF, 0);
    @(posedge clk); #1;
    cycle();
    cycle();
    reset = 1'b1;
    cycle();
    chk("first_gnt_r0", og0, 1'b1);
    set0(0, 0, 32'h0, 32'h0, 4'h0);
    cycle();

    // r0 alone: write then read back
    set1(0, 0, 32'h0, 32'h0, 4'h0, 0);
    set0(1, 1, 32'h10, 32'hDEADBEEF, 4'hF);
    cycle();
    set0(1, 0, 32'h10, 32'h0, 4'hF);
    cycle();
    set0(0, 0, 32'h0, 32'h0, 4'h0);
    cycle();
    chk("rb_rvalid", orv0, 1'b1);
    chk("rb_rdata", ord0, 32'hDEADBEEF);
    chk("rb_r1_rvalid", orv1, 1'b0);

    // r1 preload (leaves last on r1)
    set1(1, 1, 32'h20, 32'h11223344, 4'hF, 0);
    cycle();

    // contention: continuous reads on both ports
    set0(1, 0, 32'h10, 32'h0, 4'hF);
    set1(1, 0, 32'h20, 32'h0, 4'hF, 0);
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("alt_r0", og0, (i % 2) == 0);
      if (i > 0) chk("alt_rv1", orv1, (i % 2) == 0);
    end
    set0(0, 0, 32'h0, 32'h0, 4'h0);
    set1(0, 0, 32'h0, 32'h0, 4'h0, 0);
    cycle();

    // byte enables
    set1(1, 1, 32'h20, 32'hAABBCCDD, 4'h3, 0);
    cycle();
    set1(1, 0, 32'h20, 32'h0, 4'hF, 0);
    cycle();
    set1(0, 0, 32'h0, 32'h0, 4'h0, 0);
    cycle();
    chk("be_rdata", ord1, 32'h1122CCDD);

    // read granted, then reset on the next edge
    set0(1, 0, 32'h10, 32'h0, 4'hF);
    cycle();
    reset = 1'b0;
    set0(0, 0, 32'h0, 32'h0, 4'h0);
    cycle();
    chk("midrst_rvalid", orv0, 1'b0);
    reset = 1'b1;
    cycle();

`ifdef DMEM_ARB_LOCK_EN
    // r1 lock held, r0 starved until forced release
    set1(1, 1, 32'h30, 32'h5, 4'hF, 1);
    cycle();
    set0(1, 0, 32'h10, 32'h0, 4'hF);
    starve = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (og0) break;
      starve++;
    end
    chk("lock_starve", starve, 4);
    set0(0, 0, 32'h0, 32'h0, 4'h0);
    set1(0, 0, 32'h0, 32'h0, 4'h0, 0);
    cycle();
`endif

    // random traffic
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 39) != 0);
      if (bus.r0_req && !eg0) begin
        if ($urandom_range(0, 9) == 0) bus.r0_req = 1'b0;
      end else begin
        rnd(q, w, a, d, be);
        set0(q, w, a, d, be);
      end
      if (bus.r1_req && !eg1) begin
        if ($urandom_range(0, 9) == 0) bus.r1_req = 1'b0;
      end else begin
        rnd(q, w, a, d, be);
        lk = ($urandom_range(0, 4) == 0);
        set1(q, w, a, d, be, lk);
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
